// File: rtl/tc_fetch_assembler.sv
// Fetch stage for the byte-wide program ROM: issues byte addresses, packs the returned
// bytes into INSTR_BYTES-wide little-endian words, and hands them to decode via valid/ready.
module tc_fetch_assembler #(
    parameter int          INSTR_BYTES = 4,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [15:0]              prog_addr,
    input  logic [7:0]               prog_data,
    output logic [8*INSTR_BYTES-1:0] instr,
    output logic [15:0]              instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     jump_valid,
    input  logic [15:0]              jump_addr
);
    localparam int CW = $clog2(INSTR_BYTES + 1);
    localparam int WW = 8 * INSTR_BYTES;
    localparam logic [CW-1:0] CNT_FULL = CW'(INSTR_BYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(INSTR_BYTES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    logic [15:0]   fetch_addr_q, fetch_addr_d;
    logic [CW-1:0] issued_cnt_q, issued_cnt_d;
    logic [CW-1:0] recv_cnt_q, recv_cnt_d;
    logic          pending_q, pending_d;
    logic [15:0]   word_pc_q, word_pc_d;
    logic [WW-1:0] asm_q, asm_d;
    logic [WW-1:0] instr_q, instr_d;
    logic [15:0]   instr_pc_q, instr_pc_d;
    logic          instr_valid_q, instr_valid_d;

    logic          issue_s;
    logic          complete_s;
    logic          transfer_s;
    logic [WW-1:0] asm_word_s;

    // Issue/capture/transfer decisions and next-state for all fetch registers.
    always_comb begin
        issue_s    = (issued_cnt_q < CNT_FULL) && !jump_valid;
        complete_s = (recv_cnt_q == CNT_FULL) || (pending_q && (recv_cnt_q == CNT_LAST));
        transfer_s = complete_s && (!instr_valid_q || instr_ready) && !jump_valid;

        // The byte arriving this cycle is merged here so the last byte can bypass into instr.
        asm_word_s = asm_q;
        for (int i = 0; i < INSTR_BYTES; i++) begin
            if (pending_q && (recv_cnt_q == CW'(i))) begin
                asm_word_s[i*8 +: 8] = prog_data;
            end else begin
                asm_word_s[i*8 +: 8] = asm_q[i*8 +: 8];
            end
        end

        fetch_addr_d  = fetch_addr_q;
        issued_cnt_d  = issued_cnt_q;
        recv_cnt_d    = recv_cnt_q;
        pending_d     = 1'b0;
        word_pc_d     = word_pc_q;
        asm_d         = asm_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (jump_valid) begin
            fetch_addr_d  = jump_addr;
            issued_cnt_d  = '0;
            recv_cnt_d    = '0;
            instr_valid_d = 1'b0;
        end else begin
            pending_d = issue_s;
            if (issue_s) begin
                fetch_addr_d = fetch_addr_q + 16'd1;
                issued_cnt_d = issued_cnt_q + CNT_ONE;
                if (issued_cnt_q == '0) begin
                    word_pc_d = fetch_addr_q;
                end else begin
                    word_pc_d = word_pc_q;
                end
            end else begin
                fetch_addr_d = fetch_addr_q;
            end

            if (transfer_s) begin
                instr_d       = asm_word_s;
                instr_pc_d    = word_pc_q;
                instr_valid_d = 1'b1;
                issued_cnt_d  = '0;
                recv_cnt_d    = '0;
            end else begin
                if (pending_q) begin
                    asm_d      = asm_word_s;
                    recv_cnt_d = recv_cnt_q + CNT_ONE;
                end else begin
                    asm_d = asm_q;
                end
                if (instr_valid_q && instr_ready) begin
                    instr_valid_d = 1'b0;
                end else begin
                    instr_valid_d = instr_valid_q;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_addr_q  <= RESET_PC;
            issued_cnt_q  <= '0;
            recv_cnt_q    <= '0;
            pending_q     <= 1'b0;
            word_pc_q     <= 16'h0000;
            asm_q         <= '0;
            instr_q       <= '0;
            instr_pc_q    <= 16'h0000;
            instr_valid_q <= 1'b0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            issued_cnt_q  <= issued_cnt_d;
            recv_cnt_q    <= recv_cnt_d;
            pending_q     <= pending_d;
            word_pc_q     <= word_pc_d;
            asm_q         <= asm_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign prog_addr   = fetch_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
endmodule
